// File: rtl/and_func.sv
`default_nettype none
// ============================================================================
//  Module   : and_func
//  Brief    : Bitwise AND unit. A combinational result path plus a one-cycle
//             registered path with zero/sign/overflow flags and a valid strobe.
//  Revision : 1.0 - initial release
// ============================================================================
module and_func #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic [WIDTH-1:0] result_q,
  output logic             zf_q,
  output logic             sf_q,
  output logic             of_q,
  output logic             out_valid
);

  // Raw bit pattern AND; signedness only matters for the sign flag.
  logic [WIDTH-1:0] w_and;

  // Next-state values for the registered outputs.
  logic [WIDTH-1:0] result_d;
  logic             zf_d;
  logic             sf_d;
  logic             of_d;
  logic             out_valid_d;

  // Combinational outputs stay live through reset and ignore in_valid.
  always_comb begin
    w_and    = a & b;
    result   = w_and;
    overflow = 1'b0;   // a logical AND can never overflow
  end

  // Capture on in_valid; otherwise hold the data/flags and drop the strobe.
  always_comb begin
    result_d    = result_q;
    zf_d        = zf_q;
    sf_d        = sf_q;
    of_d        = of_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      result_d    = w_and;
      zf_d        = (w_and == '0);
      sf_d        = w_and[WIDTH-1];
      of_d        = 1'b0;
      out_valid_d = 1'b1;
    end
  end

  // Output registers; reset clears them immediately, without a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q  <= '0;
      zf_q      <= 1'b1;   // reset result is zero, so the zero flag is set
      sf_q      <= 1'b0;
      of_q      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      result_q  <= result_d;
      zf_q      <= zf_d;
      sf_q      <= sf_d;
      of_q      <= of_d;
      out_valid <= out_valid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_and_func.sv
`default_nettype none
// ============================================================================
//  Module   : tb_and_func
//  Brief    : Self-checking bench for and_func: directed literal cases plus
//             randomized operands/valid/reset against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_and_func;

  localparam int WIDTH = 64;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic [WIDTH-1:0] result_q;
  logic             zf_q;
  logic             sf_q;
  logic             of_q;
  logic             out_valid;

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  and_func #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .result    (result),
    .overflow  (overflow),
    .result_q  (result_q),
    .zf_q      (zf_q),
    .sf_q      (sf_q),
    .of_q      (of_q),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // Behavioural model: the last accepted product plus a "fresh this cycle" bit.
  logic [WIDTH-1:0] m_val;
  bit               m_fresh;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_val   <= '0;
      m_fresh <= 1'b0;
    end else begin
      m_fresh <= in_valid;
      if (in_valid) m_val <= a & b;
    end
  end

  task automatic chk(input string name, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      chk("cmp_result",    result,            a & b);
      chk("cmp_overflow",  {63'd0, overflow}, '0);
      chk("cmp_result_q",  result_q,          m_val);
      chk("cmp_zf_q",      {63'd0, zf_q},     {63'd0, m_val == '0});
      chk("cmp_sf_q",      {63'd0, sf_q},     {63'd0, m_val[WIDTH-1]});
      chk("cmp_of_q",      {63'd0, of_q},     '0);
      chk("cmp_out_valid", {63'd0, out_valid},{63'd0, m_fresh});
    end
  end

  // Drive one operand pair with capture, check comb result now and the
  // registered values after the capturing edge against literal expectations.
  task automatic directed(input string name, input logic [WIDTH-1:0] ta,
                          input logic [WIDTH-1:0] tb, input logic [WIDTH-1:0] er,
                          input bit ezf, input bit esf);
    @(posedge clk); #2;
    a = ta; b = tb; in_valid = 1'b1;
    #1 chk({name, "_comb"}, result, er);
    @(posedge clk); #1;
    chk({name, "_rq"},  result_q,          er);
    chk({name, "_zf"},  {63'd0, zf_q},     {63'd0, ezf});
    chk({name, "_sf"},  {63'd0, sf_q},     {63'd0, esf});
    chk({name, "_of"},  {63'd0, of_q},     '0);
    chk({name, "_ov"},  {63'd0, out_valid},64'd1);
    #1 in_valid = 1'b0;
  endtask

  logic [WIDTH-1:0] pa [4];
  logic [WIDTH-1:0] pb [4];
  logic [WIDTH-1:0] pq [4];
  bit               pv [4];

  initial begin
    // Asynchronous reset with no clock edge needed.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_result_q",  result_q,          '0);
    chk("rst_zf_q",      {63'd0, zf_q},     64'd1);
    chk("rst_sf_q",      {63'd0, sf_q},     '0);
    chk("rst_of_q",      {63'd0, of_q},     '0);
    chk("rst_out_valid", {63'd0, out_valid},'0);
    // in_valid during reset must not capture; comb path stays live.
    a = 64'hF0F0; b = 64'hFF00; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("rst_hold_rq",   result_q,          '0);
    chk("rst_hold_ov",   {63'd0, out_valid},'0);
    chk("rst_comb_live", result,            64'hF000);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    checking = 1'b1;

    directed("t7_16",  64'd7,  64'd16, 64'd0, 1'b1, 1'b0);
    directed("t10_5",  64'd10, 64'd5,  64'd0, 1'b1, 1'b0);
    directed("t12_10", 64'd12, 64'd10, 64'd8, 1'b0, 1'b0);
    directed("t64_m69", 64'd64, 64'hFFFF_FFFF_FFFF_FFBB, 64'd0, 1'b1, 1'b0);
    directed("tm1_msb", 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
             64'h8000_0000_0000_0000, 1'b0, 1'b1);
    directed("tmix", 64'hAAAA_AAAA_AF5D_8271, 64'hFFFF_FFFC_0000_007F,
             64'hAAAA_AAA8_0000_0071, 1'b0, 1'b1);

    // Capture, then reset between edges: registered outputs clear at once.
    @(posedge clk); #2;
    a = 64'h1234; b = 64'hFFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("mid_pre_rq", result_q, 64'h1234);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rq", result_q,          '0);
    chk("mid_zf", {63'd0, zf_q},     64'd1);
    chk("mid_ov", {63'd0, out_valid},'0);
    a = 64'h00FF; b = 64'h0F0F;
    #1 chk("mid_comb", result, 64'h000F);
    @(posedge clk); #1;
    chk("mid_discard", result_q, '0);
    #1 rst_n = 1'b1;
    in_valid = 1'b0;

    // in_valid pattern 1,1,0,1: data holds through the gap.
    pa[0] = 64'hF0; pb[0] = 64'hFF; pv[0] = 1'b1; pq[0] = 64'hF0;
    pa[1] = 64'h0F; pb[1] = 64'h3C; pv[1] = 1'b1; pq[1] = 64'h0C;
    pa[2] = 64'hFF; pb[2] = 64'hFF; pv[2] = 1'b0; pq[2] = 64'h0C;
    pa[3] = 64'h81; pb[3] = 64'h01; pv[3] = 1'b1; pq[3] = 64'h01;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i > 0) begin
        chk("pat_ov", {63'd0, out_valid}, {63'd0, pv[i-1]});
        chk("pat_rq", result_q, pq[i-1]);
      end
      #1;
      if (i < 4) begin
        a = pa[i]; b = pb[i]; in_valid = pv[i];
      end else begin
        in_valid = 1'b0;
      end
    end

    // Randomized operands, valid and occasional reset pulses.
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #2;
      case ($urandom_range(0, 7))
        0: a = '0;
        1: a = '1;
        2: a = 64'h8000_0000_0000_0000;
        default: a = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = '1;
        default: b = {$urandom, $urandom};
      endcase
      in_valid = ($urandom_range(0, 3) != 0);
      rst_n    = ($urandom_range(0, 39) != 0);
    end
    @(posedge clk); #2;
    rst_n = 1'b1; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checking = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
